student_serial_loader: RTL and testbench

Serial-to-parallel front end for the 16-bit register path. It accepts a qualified 1-bit stream MSB-first and assembles N-bit words. For each completed word it presents the word with a one-cycle `load` pulse, so its `word`/`load` outputs drive a register's `in`/`load` directly. It sits immediately upstream of the register and lets test fixtures and I/O fill registers and RAM one bit at a time.

---
 rtl/student_serial_loader.sv | 138 +++++++++++++
 tb/tb_student_serial_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/student_serial_loader.sv
// student_serial_loader
// Serial-to-parallel front end: assembles N-bit words from an MSB-first,
// valid-qualified bit stream and presents each finished word with a
// one-cycle load pulse, ready to drive a register's in/load pins.
// Optional feature macro: SERIAL_PARITY_EN (adds an even-parity bit after
// each word; a mismatch discards the word and pulses err).
module student_serial_loader #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ser_in,
  input  logic         ser_valid,
  output logic         ser_ready,
  input  logic         clear,
  output logic [N-1:0] word,
  output logic         load,
  output logic         busy,
  output logic         err
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    LOAD   = 3'd2
`ifdef SERIAL_PARITY_EN
    ,
    PARITY = 3'd3,
    ERR    = 3'd4
`endif
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N-1:0]  shift_reg, shift_next;
  logic [N-1:0]  word_reg, word_next;

  // State and datapath registers; reset outranks clear and everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      word_reg  <= word_next;
    end
  end

  // Next-state, datapath update and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    word_next  = word_reg;
    ser_ready  = 1'b0;
    load       = 1'b0;
    err        = 1'b0;

    case (state_reg)
      IDLE, SHIFT: begin
        ser_ready = 1'b1;
        if (clear) begin
          // Abort the partial word; a bit offered alongside clear is dropped.
          state_next = IDLE;
          cnt_next   = '0;
          shift_next = '0;
        end else if (ser_valid) begin
          shift_next = {shift_reg[N-2:0], ser_in};
          if (cnt_reg == LAST) begin
            cnt_next = '0;
`ifdef SERIAL_PARITY_EN
            state_next = PARITY;
`else
            // Word is captured on the way into LOAD so it is valid with load.
            state_next = LOAD;
            word_next  = {shift_reg[N-2:0], ser_in};
`endif
          end else begin
            cnt_next   = cnt_reg + 1'b1;
            state_next = SHIFT;
          end
        end
      end

`ifdef SERIAL_PARITY_EN
      PARITY: begin
        ser_ready = 1'b1;
        if (clear) begin
          state_next = IDLE;
          cnt_next   = '0;
          shift_next = '0;
        end else if (ser_valid) begin
          // Even parity: XOR of all data bits plus the parity bit must be 0.
          if ((^shift_reg) == ser_in) begin
            state_next = LOAD;
            word_next  = shift_reg;
          end else begin
            state_next = ERR;
          end
        end
      end

      ERR: begin
        // Result already committed: clear is ignored here, word is untouched.
        err        = 1'b1;
        state_next = IDLE;
      end
`endif

      LOAD: begin
        // Result already committed: clear is ignored here.
        load       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign word = word_reg;

`ifdef SERIAL_PARITY_EN
  assign busy = (cnt_reg != '0) || (state_reg == PARITY);
`else
  assign busy = (cnt_reg != '0);
`endif

endmodule

// File: tb/tb_student_serial_loader.sv
// Directed testbench for student_serial_loader (N = 16) with a word scoreboard.
module tb_student_serial_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_in;
  logic        ser_valid;
  logic        ser_ready;
  logic        clear;
  logic [15:0] word;
  logic        load;
  logic        busy;
  logic        err;

  student_serial_loader #(.N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .clear     (clear),
    .word      (word),
    .load      (load),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          load_cnt = 0;
  int          err_cnt = 0;
  int          last_load_cyc = -1;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic [15:0] exp_w;
    @(posedge clk);
    #1;
    cyc++;
    if (load === 1'b1) begin
      load_cnt++;
      last_load_cyc = cyc;
      $display("[TB] cycle %0d load word=%h", cyc, word);
      if (sb.size() == 0) begin
        chk("unexpected_load", {31'd0, load}, 32'd0);
      end else begin
        exp_w = sb.pop_front();
        chk("load_word", {16'd0, word}, {16'd0, exp_w});
      end
    end
    if (err === 1'b1) begin
      err_cnt++;
      $display("[TB] cycle %0d err pulse word=%h", cyc, word);
    end
  endtask

  // Offer data[nbits-1:0] MSB first, waiting on ser_ready for each bit.
  task automatic send_bits(input logic [16:0] data, input int nbits, input bit gapped);
    int waited;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (gapped && ($urandom_range(0, 2) == 0)) begin
        ser_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          tick();
          if (i != nbits - 1) chk("busy_gap", {31'd0, busy}, 32'd1);
        end
      end
      ser_valid = 1'b1;
      ser_in    = data[i];
      waited    = 0;
      while (ser_ready !== 1'b1 && waited < 20) begin
        tick();
        waited++;
      end
      if (waited >= 20) chk("ready_timeout", {31'd0, ser_ready}, 32'd1);
      tick();
    end
    ser_valid = 1'b0;
  endtask

  initial begin
    int c0;
    int l0;
    int c1;
    int e0;

    rst_n     = 1'b0;
    ser_in    = 1'b0;
    ser_valid = 1'b1;
    clear     = 1'b0;

    // Reset with valid bits offered: nothing may be captured.
    repeat (2) begin
      ser_in = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_word",  {16'd0, word},      32'h0);
    chk("rst_load",  {31'd0, load},      32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_ready", {31'd0, ser_ready}, 32'd1);
    chk("rst_err",   {31'd0, err},       32'd0);
    rst_n     = 1'b1;
    ser_valid = 1'b0;
    tick();
    chk("rst_no_capture", {31'd0, busy}, 32'd0);

    // Continuous stream 0xBEEF.
    c0 = cyc;
    l0 = load_cnt;
    sb.push_back(16'hBEEF);
    send_bits({1'b0, 16'hBEEF}, 16, 1'b0);
    chk("beef_load_high",  {31'd0, load},      32'd1);
    chk("beef_ready_low",  {31'd0, ser_ready}, 32'd0);
    chk("beef_load_cycle", 32'(last_load_cyc), 32'(c0 + 16));
    tick();
    chk("beef_load_drop",  {31'd0, load}, 32'd0);
    tick();
    chk("beef_load_once",  32'(load_cnt - l0), 32'd1);

    // Gapped stream 0x1234.
    l0 = load_cnt;
    sb.push_back(16'h1234);
    send_bits({1'b0, 16'h1234}, 16, 1'b1);
    tick();
    chk("gap_load_once", 32'(load_cnt - l0), 32'd1);
    chk("gap_word_hold", {16'd0, word}, 32'h1234);

    // Clear mid-word after 7 ones, with a valid bit offered alongside clear.
    l0 = load_cnt;
    send_bits(17'h1FFFF, 7, 1'b0);
    chk("clr_busy_before", {31'd0, busy}, 32'd1);
    chk("clr_word_before", {16'd0, word}, 32'h1234);
    clear     = 1'b1;
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    tick();
    clear     = 1'b0;
    ser_valid = 1'b0;
    chk("clr_busy_after", {31'd0, busy}, 32'd0);
    chk("clr_word_after", {16'd0, word}, 32'h1234);
    sb.push_back(16'h00A5);
    send_bits({1'b0, 16'h00A5}, 16, 1'b0);
    tick();
    chk("clr_load_once", 32'(load_cnt - l0), 32'd1);

    // Back-to-back words with ser_valid held high across the LOAD bubble.
    l0 = load_cnt;
    sb.push_back(16'h8001);
    sb.push_back(16'h7FFE);
    send_bits({1'b0, 16'h8001}, 16, 1'b0);
    c1 = last_load_cyc;
    send_bits({1'b0, 16'h7FFE}, 16, 1'b0);
    chk("b2b_spacing", 32'(last_load_cyc - c1), 32'd17);
    tick();
    chk("b2b_loads", 32'(load_cnt - l0), 32'd2);

`ifdef SERIAL_PARITY_EN
    // Parity match: 0x0003 has even weight, parity bit 0.
    l0 = load_cnt;
    sb.push_back(16'h0003);
    send_bits({16'h0003, 1'b0}, 17, 1'b0);
    tick();
    chk("par_ok_load", 32'(load_cnt - l0), 32'd1);
    chk("par_ok_word", {16'd0, word}, 32'h0003);

    // Parity mismatch: 0x0007 has odd weight, parity bit 0.
    l0 = load_cnt;
    e0 = err_cnt;
    send_bits({16'h0007, 1'b0}, 17, 1'b0);
    chk("par_err_high",  {31'd0, err},       32'd1);
    chk("par_err_ready", {31'd0, ser_ready}, 32'd0);
    tick();
    chk("par_err_drop",  {31'd0, err}, 32'd0);
    chk("par_err_once",  32'(err_cnt - e0), 32'd1);
    chk("par_err_noload", 32'(load_cnt - l0), 32'd0);
    chk("par_err_word",  {16'd0, word}, 32'h0003);
    e0 = 1;
`else
    e0 = 0;
`endif

    repeat (3) tick();
    chk("sb_empty",  32'(sb.size()), 32'd0);
    chk("err_total", 32'(err_cnt), 32'(e0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
